// File: rtl/rdid_controller.sv
// SPI mode-0 master that issues one RDID opcode and captures the three JEDEC ID bytes.
// One transaction per accepted start; results are published with a single-cycle done pulse.
module rdid_controller #(
   parameter int         CLK_DIV  = 4,
   parameter logic [7:0] CMD      = 8'h9F,
   parameter int         DESELECT = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       miso,
   output logic       cs_n,
   output logic       sclk,
   output logic       mosi,
   output logic       busy,
   output logic       done,
   output logic [7:0] manufacturer_id,
   output logic [7:0] memory_type,
   output logic [7:0] capacity
);

   localparam int TMAX = (CLK_DIV > DESELECT) ? CLK_DIV : DESELECT;
   localparam int TW   = $clog2(TMAX + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_LOW, S_HIGH, S_HOLD, S_DESELECT
   } state_t;

   state_t        state;
   logic [TW-1:0] tmr;
   logic [5:0]    bit_cnt;
   logic [31:0]   tx_sr;
   logic [23:0]   rx_sr;
   logic          start_q;

   // start is registered once so every output changes one edge after it is sampled
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= S_IDLE;
         tmr             <= '0;
         bit_cnt         <= '0;
         tx_sr           <= '0;
         rx_sr           <= '0;
         start_q         <= 1'b0;
         cs_n            <= 1'b1;
         sclk            <= 1'b0;
         mosi            <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         manufacturer_id <= 8'h00;
         memory_type     <= 8'h00;
         capacity        <= 8'h00;
      end else begin
         start_q <= start;
         done    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_q) begin
                  state   <= S_SETUP;
                  cs_n    <= 1'b0;
                  busy    <= 1'b1;
                  mosi    <= CMD[7];
                  tx_sr   <= {CMD[6:0], 25'h0};
                  bit_cnt <= '0;
                  tmr     <= '0;
               end
            end
            S_SETUP, S_LOW: begin
               if (tmr == TW'(CLK_DIV - 1)) begin
                  state <= S_HIGH;
                  sclk  <= 1'b1;
                  rx_sr <= {rx_sr[22:0], miso};
                  tmr   <= '0;
               end else begin
                  tmr <= tmr + TW'(1);
               end
            end
            S_HIGH: begin
               if (tmr == TW'(CLK_DIV - 1)) begin
                  sclk    <= 1'b0;
                  tmr     <= '0;
                  bit_cnt <= bit_cnt + 6'd1;
                  if (bit_cnt == 6'd31) begin
                     state <= S_HOLD;
                     mosi  <= 1'b0;
                  end else begin
                     // command bits are exhausted after 8 shifts; zeros follow
                     state <= S_LOW;
                     mosi  <= tx_sr[31];
                     tx_sr <= {tx_sr[30:0], 1'b0};
                  end
               end else begin
                  tmr <= tmr + TW'(1);
               end
            end
            S_HOLD: begin
               if (tmr == TW'(CLK_DIV - 1)) begin
                  state           <= S_DESELECT;
                  cs_n            <= 1'b1;
                  mosi            <= 1'b0;
                  done            <= 1'b1;
                  manufacturer_id <= rx_sr[23:16];
                  memory_type     <= rx_sr[15:8];
                  capacity        <= rx_sr[7:0];
                  tmr             <= '0;
               end else begin
                  tmr <= tmr + TW'(1);
               end
            end
            S_DESELECT: begin
               if (tmr == TW'(DESELECT - 1)) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                  tmr   <= '0;
               end else begin
                  tmr <= tmr + TW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rdid_controller.sv
// Directed bench for rdid_controller: default-divider instance with a mode-0 flash model,
// plus a CLK_DIV=1 instance whose miso is held high.
module tb_rdid_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       start_b = 1'b0;
   logic       miso;
   logic       miso_b = 1'b1;
   logic       cs_n, sclk, mosi, busy, done;
   logic [7:0] mid, mty, cap;
   logic       cs_n_b, sclk_b, mosi_b, busy_b, done_b;
   logic [7:0] mid_b, mty_b, cap_b;

   always #5 clk = ~clk;

   rdid_controller dut (
      .clk(clk), .reset(reset), .start(start), .miso(miso),
      .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .busy(busy), .done(done),
      .manufacturer_id(mid), .memory_type(mty), .capacity(cap)
   );

   rdid_controller #(.CLK_DIV(1)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .miso(miso_b),
      .cs_n(cs_n_b), .sclk(sclk_b), .mosi(mosi_b), .busy(busy_b), .done(done_b),
      .manufacturer_id(mid_b), .memory_type(mty_b), .capacity(cap_b)
   );

   // flash model: loads its frame when cs_n falls, shifts after every sclk fall
   logic [23:0] resp = 24'h0;
   logic [31:0] fl_sr = 32'h0;
   logic        cs_q = 1'b1, sclk_q = 1'b0;
   always @(posedge clk) begin
      cs_q   <= cs_n;
      sclk_q <= sclk;
      if (cs_q && !cs_n) fl_sr <= {8'h00, resp};
      else if (sclk_q && !sclk) fl_sr <= {fl_sr[30:0], 1'b0};
   end
   assign miso = fl_sr[31];

   int          rises = 0, rises_b = 0;
   logic [31:0] mosi_cap = 32'h0;
   always @(posedge sclk) begin
      rises++;
      mosi_cap = {mosi_cap[30:0], mosi};
   end
   always @(posedge sclk_b) rises_b++;

   int npass = 0, ntot = 0, cyc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // k counts edges after the edge that sampled start; extra starts are injected at edges inj_a/inj_b
   task automatic run_txn(input int inj_a, input int inj_b, output int fall_at, output int done_at,
                          output int idle_at, output int ndone, output int nlow,
                          output logic [23:0] ids_pre);
      fall_at = -1; done_at = -1; idle_at = -1; ndone = 0; nlow = 0; ids_pre = 24'h0;
      for (int k = 1; k <= 400; k++) begin
         start = (k == inj_a) || (k == inj_b);
         step();
         if (!cs_n) begin
            nlow++;
            if (fall_at < 0) fall_at = k;
         end
         if (done) begin
            ndone++;
            done_at = k;
         end
         if (k == 260) ids_pre = {mid, mty, cap};
         if (!busy) begin
            idle_at = k;
            break;
         end
      end
      start = 1'b0;
   endtask

   initial begin
      int          fall_at, done_at, idle_at, ndone, nlow, base, tog;
      logic [23:0] ids_pre;
      logic        sclk_prev;

      step(); step();
      reset = 1'b0;
      step();
      chk("reset_cs_n", cs_n, 1'b1);
      chk("reset_sclk_mosi", {sclk, mosi}, 2'b00);
      chk("reset_busy_done", {busy, done}, 2'b00);
      chk("reset_ids", {mid, mty, cap}, 24'h0);

      // first transaction
      resp = 24'h20BA19;
      base = rises;
      start = 1'b1; step(); start = 1'b0;
      run_txn(0, 0, fall_at, done_at, idle_at, ndone, nlow, ids_pre);
      chk("t1_cs_fall", fall_at, 1);
      chk("t1_done_at", done_at, 261);
      chk("t1_idle_at", idle_at, 269);
      chk("t1_ndone", ndone, 1);
      chk("t1_cs_low", nlow, 260);
      chk("t1_sclk_rises", rises - base, 32);
      chk("t1_mosi", mosi_cap, 32'h9F00_0000);
      chk("t1_ids", {mid, mty, cap}, 24'h20BA19);

      // second transaction, with ignored starts at T0+5 and T0+265
      resp = 24'hEF4018;
      base = rises;
      start = 1'b1; step(); start = 1'b0;
      run_txn(5, 265, fall_at, done_at, idle_at, ndone, nlow, ids_pre);
      chk("t2_ids_hold", ids_pre, 24'h20BA19);
      chk("t2_ids", {mid, mty, cap}, 24'hEF4018);
      chk("t2_done_at", done_at, 261);
      chk("t2_ndone", ndone, 1);
      chk("t2_sclk_rises", rises - base, 32);
      step(); step(); step();
      chk("t2_no_requeue", {cs_n, busy}, 2'b10);

      // reset mid-response
      resp = 24'h123456;
      start = 1'b1; step(); start = 1'b0;
      for (int k = 1; k < 100; k++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rst_mid_cs_sclk", {cs_n, sclk, mosi}, 3'b100);
      chk("rst_mid_busy_done", {busy, done}, 2'b00);
      chk("rst_mid_ids", {mid, mty, cap}, 24'h0);
      ndone = 0;
      for (int k = 0; k < 12; k++) begin
         step();
         if (done || !cs_n) ndone++;
      end
      chk("rst_mid_quiet", ndone, 0);

      resp = 24'hC22817;
      start = 1'b1; step(); start = 1'b0;
      run_txn(0, 0, fall_at, done_at, idle_at, ndone, nlow, ids_pre);
      chk("t3_ids", {mid, mty, cap}, 24'hC22817);
      chk("t3_done_at", done_at, 261);

      // start and reset together in idle
      reset = 1'b1; start = 1'b1;
      step();
      reset = 1'b0; start = 1'b0;
      nlow = 0;
      for (int k = 0; k < 6; k++) begin
         step();
         if (!cs_n || busy) nlow++;
      end
      chk("start_reset_idle", nlow, 0);

      // CLK_DIV=1 instance, miso stuck high
      base = rises_b;
      start_b = 1'b1; step(); start_b = 1'b0;
      nlow = 0; tog = 0; done_at = -1; idle_at = -1;
      sclk_prev = sclk_b;
      for (int k = 1; k <= 200; k++) begin
         step();
         if (!cs_n_b) nlow++;
         if (sclk_b != sclk_prev) tog++;
         sclk_prev = sclk_b;
         if (done_b) done_at = k;
         if (!busy_b) begin
            idle_at = k;
            break;
         end
      end
      chk("div1_cs_low", nlow, 65);
      chk("div1_sclk_toggles", tog, 64);
      chk("div1_sclk_rises", rises_b - base, 32);
      chk("div1_done_at", done_at, 66);
      chk("div1_idle_at", idle_at, 74);
      chk("div1_ids", {mid_b, mty_b, cap_b}, 24'hFFFFFF);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
